// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock synchronous FIFO.
// Programmable almost-full/almost-empty thresholds, registered occupancy count,
// one-cycle overflow/underflow pulses for rejected requests.
// Optional feature macro: FIFO_FWFT_EN selects first-word-fall-through output;
// when undefined, dout is registered with one cycle of read latency.
module fifo_sync_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wen,
  input  logic                     ren,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_afull;
  logic              r_aempty;
  logic              r_ovf;
  logic              r_udf;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic [CW-1:0]     w_count_nxt;

  // A read frees a slot in the same edge, so a full FIFO still accepts a
  // write when a read is accepted alongside it.
  assign w_rd_acc    = ren & ~r_empty;
  assign w_wr_acc    = wen & (~r_full | w_rd_acc);
  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  // Storage: written only on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // Occupancy and all flags are registered from the next-state count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= CW'(AFULL_TH));
      r_aempty <= (w_count_nxt <= CW'(AEMPTY_TH));
    end
  end

  // Rejection pulses: one cycle per rejected request, re-pulsing while it persists.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= wen & ~w_wr_acc;
      r_udf <= ren & ~w_rd_acc;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data; zero when empty.
  assign dout = r_empty ? '0 : r_mem[r_rd_ptr];
`else
  logic [DATA_W-1:0] r_dout;

  // Registered read port: updates only on an accepted read, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_dout <= '0;
    else if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
  end

  assign dout = r_dout;
`endif

  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param at default parameters.
// Works in both output modes; define FIFO_FWFT_EN for first-word-fall-through.
module tb_fifo_sync_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wen = 1'b0;
  logic              ren = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic [DATA_W-1:0] dout;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]        count;

  fifo_sync_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .din(din), .dout(dout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  int                m_cnt = 0;
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_ovf = 1'b0;
  logic              m_udf = 1'b0;

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Drive one cycle, update the scoreboard, return 1 after the edge.
  task automatic step(input logic w, input logic r, input logic [DATA_W-1:0] d);
    logic ra, wa;
    wen = w; ren = r; din = d;
    ra = r && (m_cnt > 0);
    wa = w && ((m_cnt < DEPTH) || ra);
    @(posedge clk);
    #1;
    wen = 1'b0; ren = 1'b0;
    m_ovf = w && !wa;
    m_udf = r && !ra;
`ifdef FIFO_FWFT_EN
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    m_dout = (q.size() > 0) ? q[0] : '0;
`else
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
`endif
    m_cnt = m_cnt + int'(wa) - int'(ra);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || dout !== 8'h00 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got e=%b f=%b cnt=%0d dout=%h ae=%b af=%b ov=%b un=%b, want e=1 f=0 cnt=0 dout=00 ae=1 af=0 ov=0 un=0",
               empty, full, count, dout, almost_empty, almost_full, overflow, underflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'(i));
      n_vec++;
      if (count !== 5'(i + 1) || almost_empty !== ((i + 1) <= AE) || almost_full !== ((i + 1) >= AF) ||
          full !== ((i + 1) == DEPTH) || empty !== 1'b0 || overflow !== 1'b0) begin
        n_err++;
        $display("FAIL fill[%0d]: got cnt=%0d ae=%b af=%b f=%b e=%b ov=%b, want cnt=%0d ae=%b af=%b f=%b e=0 ov=0",
                 i, count, almost_empty, almost_full, full, empty, overflow,
                 i + 1, (i + 1) <= AE, (i + 1) >= AF, (i + 1) == DEPTH);
      end
    end
    step(1'b1, 1'b0, 8'hAA);
    n_vec++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      n_err++;
      $display("FAIL overflow: got ov=%b cnt=%0d f=%b, want ov=1 cnt=16 f=1", overflow, count, full);
    end
    step(1'b0, 1'b0, 8'h00);
    n_vec++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      n_err++;
      $display("FAIL overflow_clear: got ov=%b cnt=%0d, want ov=0 cnt=16", overflow, count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      n_vec++;
      if (dout !== m_dout || count !== 5'(m_cnt) || empty !== (m_cnt == 0) || underflow !== 1'b0) begin
        n_err++;
        $display("FAIL drain[%0d]: got dout=%h cnt=%0d e=%b un=%b, want dout=%h cnt=%0d e=%b un=0",
                 i, dout, count, empty, underflow, m_dout, m_cnt, m_cnt == 0);
      end
    end
    step(1'b0, 1'b1, 8'h00);
    n_vec++;
`ifdef FIFO_FWFT_EN
    if (underflow !== 1'b1 || dout !== 8'h00 || empty !== 1'b1) begin
`else
    if (underflow !== 1'b1 || dout !== 8'h0F || empty !== 1'b1) begin
`endif
      n_err++;
      $display("FAIL underflow: got un=%b dout=%h e=%b, want un=1 dout=%h e=1", underflow, dout, empty, m_dout);
    end
    step(1'b0, 1'b0, 8'h00);
    n_vec++;
    if (underflow !== 1'b0) begin
      n_err++;
      $display("FAIL underflow_clear: got un=%b, want 0", underflow);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    step(1'b1, 1'b1, 8'hC8);
    n_vec++;
    if (count !== 5'd8 || dout !== m_dout || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_err++;
      $display("FAIL rw_mid: got cnt=%0d dout=%h, want cnt=8 dout=%h", count, dout, m_dout);
    end
    while (m_cnt < DEPTH) step(1'b1, 1'b0, 8'(8'hD0 + m_cnt));
    step(1'b1, 1'b1, 8'hEE);
    n_vec++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0 || dout !== m_dout) begin
      n_err++;
      $display("FAIL rw_full: got cnt=%0d f=%b ov=%b dout=%h, want cnt=16 f=1 ov=0 dout=%h",
               count, full, overflow, dout, m_dout);
    end
    while (m_cnt > 0) begin
      step(1'b0, 1'b1, 8'h00);
      n_vec++;
      if (dout !== m_dout) begin
        n_err++;
        $display("FAIL rw_drain: got dout=%h, want %h", dout, m_dout);
      end
    end
    step(1'b1, 1'b1, 8'h77);
    n_vec++;
    if (underflow !== 1'b1 || count !== 5'd1 || empty !== 1'b0) begin
      n_err++;
      $display("FAIL rw_empty: got un=%b cnt=%0d e=%b, want un=1 cnt=1 e=0", underflow, count, empty);
    end
    step(1'b0, 1'b1, 8'h00);
    n_vec++;
    if (dout !== m_dout || empty !== 1'b1) begin
      n_err++;
      $display("FAIL rw_empty_pop: got dout=%h e=%b, want dout=%h e=1", dout, empty, m_dout);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00);
      n_vec++;
      if (dout !== m_dout) begin
        n_err++;
        $display("FAIL wrap_a[%0d]: got dout=%h, want %h", i, dout, m_dout);
      end
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      n_vec++;
`ifdef FIFO_FWFT_EN
      if (dout !== m_dout) begin
`else
      if (dout !== 8'(8'h30 + i)) begin
`endif
        n_err++;
        $display("FAIL wrap_b[%0d]: got dout=%h, want %h", i, dout, m_dout);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i));
    rst_n = 1'b0;
    #2;
    model_reset();
    n_vec++;
    if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0 || dout !== 8'h00 ||
        almost_empty !== 1'b1 || almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got e=%b f=%b cnt=%0d dout=%h ae=%b af=%b, want e=1 f=0 cnt=0 dout=00 ae=1 af=0",
               empty, full, count, dout, almost_empty, almost_full);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    n_vec++;
    if (underflow !== 1'b1 || count !== 5'd0) begin
      n_err++;
      $display("FAIL reset_mid_ren: got un=%b cnt=%0d, want un=1 cnt=0", underflow, count);
    end
  endtask

  task automatic test_fwft();
    step(1'b1, 1'b0, 8'h5A);
    n_vec++;
`ifdef FIFO_FWFT_EN
    if (dout !== 8'h5A || empty !== 1'b0) begin
`else
    if (dout !== m_dout || empty !== 1'b0) begin
`endif
      n_err++;
      $display("FAIL fwft_write: got dout=%h e=%b, want dout=%h e=0", dout, empty, m_dout);
    end
    step(1'b0, 1'b1, 8'h00);
    n_vec++;
`ifdef FIFO_FWFT_EN
    if (dout !== 8'h00 || empty !== 1'b1) begin
`else
    if (dout !== 8'h5A || empty !== 1'b1) begin
`endif
      n_err++;
      $display("FAIL fwft_pop: got dout=%h e=%b, want dout=%h e=1", dout, empty, m_dout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      n_vec++;
      if (dout !== m_dout || count !== 5'(m_cnt) || overflow !== m_ovf || underflow !== m_udf ||
          full !== (m_cnt == DEPTH) || empty !== (m_cnt == 0) ||
          almost_full !== (m_cnt >= AF) || almost_empty !== (m_cnt <= AE)) begin
        n_err++;
        $display("FAIL random[%0d]: got dout=%h cnt=%0d ov=%b un=%b f=%b e=%b, want dout=%h cnt=%0d ov=%b un=%b",
                 i, dout, count, overflow, underflow, full, empty, m_dout, m_cnt, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_fwft();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
